// File: rtl/change_dispenser.sv
// Coin-change sequencer: pays an amount greedily (50/10/5/1) through a one-coin-at-a-time
// hopper handshake, tracks per-denomination stock, and reports shortfall and ack timeouts.
module change_dispenser #(
  parameter int ACK_TIMEOUT = 16,
  parameter int INIT_STOCK  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] change_amt,
  input  logic       refill,
  input  logic [1:0] refill_sel,
  input  logic [5:0] refill_cnt,
  input  logic       coin_ack,
  output logic       coin_req,
  output logic [1:0] coin_sel,
  output logic       busy,
  output logic       done,
  output logic [7:0] shortfall,
  output logic       fault,
  output logic [3:0] stock_empty,
  output logic [1:0] dbg_state
);

  // Hopper handshake: coin_req/coin_sel are held stable until coin_ack is sampled high
  // while in REQ; the coin counts as paid on that edge. coin_ack outside REQ is ignored.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SELECT = 2'd1;
  localparam logic [1:0] S_REQ    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST   = TW'(ACK_TIMEOUT - 1);
  localparam logic [5:0]    STOCK_INIT = 6'(INIT_STOCK);

  function automatic logic [7:0] coin_value(input logic [1:0] code);
    case (code)
      2'd0:    coin_value = 8'd50;
      2'd1:    coin_value = 8'd10;
      2'd2:    coin_value = 8'd5;
      default: coin_value = 8'd1;
    endcase
  endfunction

  logic [1:0]    state_q, state_d;
  logic [7:0]    remain_q, remain_d;
  logic          coin_req_q, coin_req_d;
  logic [1:0]    coin_sel_q, coin_sel_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    shortfall_q, shortfall_d;
  logic          fault_q, fault_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [5:0]    stock_q [4];
  logic [5:0]    stock_d [4];
  logic [3:0]    stock_empty_q, stock_empty_d;
  logic          sel_found;
  logic [1:0]    sel_code;
  logic          dispense;

  // Descending scan so the last hit is the lowest code, i.e. the largest coin value.
  always_comb begin
    sel_found = 1'b0;
    sel_code  = 2'd0;
    for (int d = 3; d >= 0; d--) begin
      if (coin_value(2'(d)) <= remain_q && stock_q[d] != 6'd0) begin
        sel_found = 1'b1;
        sel_code  = 2'(d);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    coin_req_d  = coin_req_q;
    coin_sel_d  = coin_sel_q;
    tmo_d       = tmo_q;
    shortfall_d = shortfall_q;
    fault_d     = fault_q;
    dispense    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          remain_d    = change_amt;
          shortfall_d = 8'd0;
          fault_d     = 1'b0;
          state_d     = (change_amt == 8'd0) ? S_DONE : S_SELECT;
        end
      end
      S_SELECT: begin
        if (sel_found) begin
          coin_sel_d = sel_code;
          coin_req_d = 1'b1;
          tmo_d      = '0;
          state_d    = S_REQ;
        end else begin
          shortfall_d = remain_q;
          state_d     = S_DONE;
        end
      end
      S_REQ: begin
        if (coin_ack) begin
          remain_d   = remain_q - coin_value(coin_sel_q);
          dispense   = 1'b1;
          coin_req_d = 1'b0;
          state_d    = (remain_d == 8'd0) ? S_DONE : S_SELECT;
        end else if (tmo_q == TMO_LAST) begin
          coin_req_d  = 1'b0;
          fault_d     = 1'b1;
          shortfall_d = remain_q;
          state_d     = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Refill and dispense may hit the same counter in one cycle; result saturates at 63.
  always_comb begin
    logic [7:0] sum;
    for (int d = 0; d < 4; d++) begin
      sum = {2'b00, stock_q[d]};
      if (refill && refill_sel == 2'(d)) sum = sum + {2'b00, refill_cnt};
      if (dispense && coin_sel_q == 2'(d)) sum = sum - 8'd1;
      stock_d[d]       = (sum > 8'd63) ? 6'd63 : sum[5:0];
      stock_empty_d[d] = (stock_d[d] == 6'd0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      remain_q      <= 8'd0;
      coin_req_q    <= 1'b0;
      coin_sel_q    <= 2'd0;
      tmo_q         <= '0;
      shortfall_q   <= 8'd0;
      fault_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      stock_empty_q <= {4{STOCK_INIT == 6'd0}};
      for (int d = 0; d < 4; d++) stock_q[d] <= STOCK_INIT;
    end else begin
      state_q       <= state_d;
      remain_q      <= remain_d;
      coin_req_q    <= coin_req_d;
      coin_sel_q    <= coin_sel_d;
      tmo_q         <= tmo_d;
      shortfall_q   <= shortfall_d;
      fault_q       <= fault_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      stock_empty_q <= stock_empty_d;
      for (int d = 0; d < 4; d++) stock_q[d] <= stock_d[d];
    end
  end

  assign coin_req    = coin_req_q;
  assign coin_sel    = coin_sel_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign shortfall   = shortfall_q;
  assign fault       = fault_q;
  assign stock_empty = stock_empty_q;
  assign dbg_state   = state_q;

endmodule
